// File: rtl/multicycle_control_fsm.sv
// Main control unit for the multicycle RISC-V datapath: instruction sequencer,
// ALU decoder and immediate-type decoder.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | read instruction at PC into IR, PC <= PC + 4
// DECODE   | read registers, compute branch target OldPC + imm
// MEMADR   | compute load/store address A + imm
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to register file
// MEMWRITE | write B register to data memory at ALUOut
// EXECUTER | R-type ALU operation A op B
// EXECUTEI | I-type ALU operation A op imm
// ALUWB    | write ALUOut to register file
// BEQ      | compare A - B, update PC with branch target when zero
// JAL      | PC <= target, compute return address OldPC + 4
module multicycle_control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   state_t     state_q, state_d;
   logic       pc_update, branch;
   logic       mem_write_raw, ir_write_raw, reg_write_raw;
   logic [1:0] alu_op;

   // State register; reset low drops straight back to FETCH without a clock
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Next-state sequencing
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // Per-state datapath controls; unused codes leave everything at zero
   always_comb begin
      pc_update     = 1'b0;
      branch        = 1'b0;
      AdrSrc        = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      alu_op        = 2'b00;
      case (state_q)
         S_FETCH: begin
            ir_write_raw = 1'b1;
            ALUSrcB      = 2'b10;
            ResultSrc    = 2'b10;
            pc_update    = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc     = 2'b01;
            reg_write_raw = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc        = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b10;
         end
         S_EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = 2'b10;
         end
         S_ALUWB: reg_write_raw = 1'b1;
         S_BEQ: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b01;
            branch  = 1'b1;
         end
         S_JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   // Write enables are gated by reset so no write can land while it is low
   assign PCWrite  = reset & (pc_update | (branch & zero));
   assign MemWrite = reset & mem_write_raw;
   assign IRWrite  = reset & ir_write_raw;
   assign RegWrite = reset & reg_write_raw;
   assign state    = state_q;

   // ALU decoder; subtract for R-type funct3=000 only when op[5] marks R-type
   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   // Immediate format from the opcode alone
   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

endmodule
